// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, FSM states, flag bit positions.
// MUL state exists only when ALU_CORE_MUL_EN is defined.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

`ifdef ALU_CORE_MUL_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_MUL  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// done is high during the final iteration; product is valid with it.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic               active_q, active_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
      done     = active_q && (cnt_q == CNT_W'(WIDTH - 1));
      product  = acc_next;
      active_d = active_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
      end else if (active_q) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (done) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/alu_core.sv
// Registered ALU with valid/ready handshake and result hold.
// Define ALU_CORE_MUL_EN to add the multi-cycle MUL (opcode 8).
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             accept;
   logic [WIDTH:0]   sum, dif;
   logic [WIDTH-1:0] shamt;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_flags;

`ifdef ALU_CORE_MUL_EN
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_prod)
   );
`endif

   always_comb begin
      sum       = {1'b0, A} + {1'b0, B};
      dif       = {1'b0, A} - {1'b0, B};
      shamt     = WIDTH'(32'(B) % WIDTH);
      alu_res   = '0;
      alu_flags = '0;
      unique case (opcode)
         OP_ADD: begin
            alu_res           = sum[WIDTH-1:0];
            alu_flags[FLAG_C] = sum[WIDTH];
            alu_flags[FLAG_V] = (A[WIDTH-1] == B[WIDTH-1])
                             && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res           = dif[WIDTH-1:0];
            alu_flags[FLAG_C] = dif[WIDTH];
            alu_flags[FLAG_V] = (A[WIDTH-1] != B[WIDTH-1])
                             && (dif[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_NOT:  alu_res = ~A;
         OP_XOR:  alu_res = A ^ B;
         OP_SHL:  alu_res = A << shamt;
         OP_SHR:  alu_res = A >> shamt;
         default: alu_res = '0;
      endcase
      alu_flags[FLAG_Z] = ~|alu_res;
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
   end

   assign in_ready  = (state_q == ST_IDLE)
                   || (state_q == ST_HOLD && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_HOLD);
   assign result    = result_q;
   assign flags     = flags_q;
`ifdef ALU_CORE_MUL_EN
   assign busy      = (state_q == ST_MUL);
`else
   assign busy      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_CORE_MUL_EN
      mul_start = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               state_d  = ST_HOLD;
               result_d = alu_res;
               flags_d  = alu_flags;
`ifdef ALU_CORE_MUL_EN
               if (opcode == OP_MUL) begin
                  state_d   = ST_MUL;
                  mul_start = 1'b1;
               end
`endif
            end else if (state_q == ST_HOLD && out_ready) begin
               state_d = ST_IDLE;
            end
         end
`ifdef ALU_CORE_MUL_EN
         ST_MUL: begin
            if (mul_done) begin
               state_d          = ST_HOLD;
               result_d         = mul_prod[WIDTH-1:0];
               flags_d          = '0;
               flags_d[FLAG_Z]  = ~|mul_prod[WIDTH-1:0];
               flags_d[FLAG_N]  = mul_prod[WIDTH-1];
               flags_d[FLAG_C]  = |mul_prod[2*WIDTH-1:WIDTH];
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Randomised self-checking bench for alu_core (WIDTH=8).
// Expectations follow ALU_CORE_MUL_EN when it is defined.
module tb_alu_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef ALU_CORE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   alu_core #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, flags packed {Z,N,C,V}.
   function automatic void model(input int a, input int b, input int op,
                                 output logic [7:0] r,
                                 output logic [3:0] f,
                                 output int lat);
      int rr, sa, sb, ss, p;
      bit c, v;
      c   = 1'b0;
      v   = 1'b0;
      lat = 1;
      sa  = (a > 127) ? a - 256 : a;
      sb  = (b > 127) ? b - 256 : b;
      case (op)
         0: begin
            rr = (a + b) & 255;
            c  = (a + b) > 255;
            ss = sa + sb;
            v  = (ss > 127) || (ss < -128);
         end
         1: begin
            rr = (a - b) & 255;
            c  = a < b;
            ss = sa - sb;
            v  = (ss > 127) || (ss < -128);
         end
         2: rr = a & b;
         3: rr = a | b;
         4: rr = (~a) & 255;
         5: rr = a ^ b;
         6: rr = (a << (b % 8)) & 255;
         7: rr = a >> (b % 8);
         8: begin
            rr = 0;
            if (MUL_ON) begin
               p   = a * b;
               rr  = p & 255;
               c   = (p >> 8) != 0;
               lat = 9;
            end
         end
         default: rr = 0;
      endcase
      r = rr[7:0];
      f = {(rr == 0), (rr > 127), c, v};
   endfunction

   // Issues one op from IDLE, waits bounded for out_valid, then consumes it.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op,
                         output logic [7:0] r, output logic [3:0] f,
                         output int lat, output int bcnt);
      @(negedge clk);
      A = a; B = b; opcode = op;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat  = -1;
      bcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         if (out_valid) begin
            lat = i;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk); #1;
      end
      r = result;
      f = flags;
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; opcode = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks += 5;
      if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_in_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy got %b want 0", busy); end
      if (result !== 8'h00) begin n_fail++;
         $display("FAIL reset_result got %h want 00", result); end
      if (flags !== 4'b0000) begin n_fail++;
         $display("FAIL reset_flags got %b want 0000", flags); end
   endtask

   task automatic test_directed();
      logic [7:0] ta [4] = '{8'h0A, 8'hFF, 8'h05, 8'h7F};
      logic [7:0] tb [4] = '{8'h05, 8'h01, 8'h0A, 8'h01};
      logic [3:0] to [4] = '{4'd0, 4'd0, 4'd1, 4'd0};
      logic [7:0] er [4] = '{8'h0F, 8'h00, 8'hFB, 8'h80};
      logic [3:0] ef [4] = '{4'b0000, 4'b1010, 4'b0110, 4'b0101};
      logic [7:0] r;
      logic [3:0] f;
      int lat, bc;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], to[i], r, f, lat, bc);
         n_checks += 3;
         if (r !== er[i]) begin n_fail++;
            $display("FAIL dir%0d_result got %h want %h", i, r, er[i]); end
         if (f !== ef[i]) begin n_fail++;
            $display("FAIL dir%0d_flags got %b want %b", i, f, ef[i]); end
         if (lat !== 1) begin n_fail++;
            $display("FAIL dir%0d_latency got %0d want 1", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      A = 8'h05; B = 8'h0A; opcode = 4'd1;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++;
         $display("FAIL bp_first_valid got %b want 1", out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks += 4;
         if (result !== 8'hFB) begin n_fail++;
            $display("FAIL bp_hold_result got %h want fb", result); end
         if (flags !== 4'b0110) begin n_fail++;
            $display("FAIL bp_hold_flags got %b want 0110", flags); end
         if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL bp_hold_valid got %b want 1", out_valid); end
         if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_in_ready got %b want 0", in_ready); end
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      A = 8'h0A; B = 8'h05; opcode = 4'd0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL bp_release_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++;
         $display("FAIL bp_b2b_valid got %b want 1", out_valid); end
      if (result !== 8'h0F) begin n_fail++;
         $display("FAIL bp_b2b_result got %h want 0f", result); end
      if (flags !== 4'b0000) begin n_fail++;
         $display("FAIL bp_b2b_flags got %b want 0000", flags); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL bp_drain_valid got %b want 0", out_valid); end
   endtask

`ifdef ALU_CORE_MUL_EN
   task automatic test_mul();
      logic [7:0] r;
      logic [3:0] f;
      int lat, bc;
      run_op(8'h0C, 8'h0B, 4'd8, r, f, lat, bc);
      n_checks += 4;
      if (r !== 8'h84) begin n_fail++;
         $display("FAIL mul1_result got %h want 84", r); end
      if (f !== 4'b0100) begin n_fail++;
         $display("FAIL mul1_flags got %b want 0100", f); end
      if (lat !== 9) begin n_fail++;
         $display("FAIL mul1_latency got %0d want 9", lat); end
      if (bc !== 8) begin n_fail++;
         $display("FAIL mul1_busy_cycles got %0d want 8", bc); end
      run_op(8'h10, 8'h10, 4'd8, r, f, lat, bc);
      n_checks += 2;
      if (r !== 8'h00) begin n_fail++;
         $display("FAIL mul2_result got %h want 00", r); end
      if (f !== 4'b1010) begin n_fail++;
         $display("FAIL mul2_flags got %b want 1010", f); end
   endtask
`endif

   task automatic test_undefined();
      logic [3:0] ops [2] = '{4'd8, 4'd15};
      logic [7:0] r;
      logic [3:0] f;
      int lat, bc;
      for (int i = 0; i < 2; i++) begin
`ifdef ALU_CORE_MUL_EN
         if (ops[i] == 4'd8) continue;
`endif
         run_op(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                ops[i], r, f, lat, bc);
         n_checks += 4;
         if (r !== 8'h00) begin n_fail++;
            $display("FAIL undef%0d_result got %h want 00", ops[i], r); end
         if (f !== 4'b1000) begin n_fail++;
            $display("FAIL undef%0d_flags got %b want 1000", ops[i], f); end
         if (lat !== 1) begin n_fail++;
            $display("FAIL undef%0d_latency got %0d want 1", ops[i], lat); end
         if (bc !== 0) begin n_fail++;
            $display("FAIL undef%0d_busy got %0d want 0", ops[i], bc); end
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
`ifdef ALU_CORE_MUL_EN
      A = 8'h0F; B = 8'h11; opcode = 4'd8;
`else
      A = 8'h0F; B = 8'h11; opcode = 4'd4;
`endif
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
`ifdef ALU_CORE_MUL_EN
      n_checks++;
      if (busy !== 1'b1) begin n_fail++;
         $display("FAIL rst_mid_busy_before got %b want 1", busy); end
`endif
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks += 5;
      if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_valid got %b want 0", out_valid); end
      if (busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_busy got %b want 0", busy); end
      if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
      if (result !== 8'h00) begin n_fail++;
         $display("FAIL rst_mid_result got %h want 00", result); end
      if (flags !== 4'b0000) begin n_fail++;
         $display("FAIL rst_mid_flags got %b want 0000", flags); end
      repeat (12) begin @(posedge clk); #1; end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_stale_valid got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      logic [7:0] a, b, r, er;
      logic [3:0] op, f, ef;
      int lat, elat, bc;
      for (int i = 0; i < 60; i++) begin
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         op = 4'($urandom_range(0, 15));
         model(a, b, op, er, ef, elat);
         run_op(a, b, op, r, f, lat, bc);
         n_checks += 3;
         if (r !== er) begin n_fail++;
            $display("FAIL rnd_result op%0d %h,%h got %h want %h",
                     op, a, b, r, er); end
         if (f !== ef) begin n_fail++;
            $display("FAIL rnd_flags op%0d %h,%h got %b want %b",
                     op, a, b, f, ef); end
         if (lat !== elat) begin n_fail++;
            $display("FAIL rnd_latency op%0d got %0d want %0d",
                     op, lat, elat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b, er;
      logic [3:0] op, ef;
      int elat, o;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         o = $urandom_range(0, 14);
         if (o >= 8) o++;
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         op = 4'(o);
         model(a, b, op, er, ef, elat);
         @(negedge clk);
         A = a; B = b; opcode = op; in_valid = 1'b1;
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b_in_ready step%0d got %b want 1",
                     i, in_ready); end
         @(posedge clk); #1;
         n_checks += 3;
         if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL b2b_valid step%0d got %b want 1",
                     i, out_valid); end
         if (result !== er) begin n_fail++;
            $display("FAIL b2b_result step%0d got %h want %h",
                     i, result, er); end
         if (flags !== ef) begin n_fail++;
            $display("FAIL b2b_flags step%0d got %b want %b",
                     i, flags, ef); end
      end
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
`ifdef ALU_CORE_MUL_EN
      test_mul();
`endif
      test_undefined();
      test_reset_mid_op();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand / shift amount.
REQ-008 SHALL have port opcode  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered {Z,N,C,V}, bit 3 = Z.
REQ-013 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.

Function
REQ-014 SHALL accept a request on any rising edge where in_valid && in_ready; A, B, opcode captured at that edge.
REQ-015 SHALL implement FSM states IDLE, MUL, HOLD; IDLE->HOLD on accept of single-cycle op; IDLE->MUL on accept of opcode 8 (if enabled); MUL->HOLD after WIDTH iterations; HOLD->IDLE on out_ready with no new accept; HOLD->HOLD/MUL on out_ready with simultaneous accept.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready); in_ready low in MUL.
REQ-017 SHALL assert out_valid only in HOLD; result and flags stable while out_valid && !out_ready.
REQ-018 SHALL present single-cycle results with out_valid high in the cycle after accept (latency 1).
REQ-019 SHALL implement opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 NOT A, 5 XOR, 6 SHL A by B mod WIDTH, 7 logical SHR A by B mod WIDTH, 8 MUL (optional); opcodes 9..15 give result 0 with latency 1.
REQ-020 SHALL wrap arithmetic modulo 2^WIDTH.
REQ-021 SHALL set Z = (result==0), N = result[WIDTH-1] for all opcodes.
REQ-022 SHALL set C = carry-out for ADD, borrow (A<B unsigned) for SUB, high product half nonzero for MUL, else 0.
REQ-023 SHALL set V = two's-complement overflow for ADD/SUB, else 0.
REQ-024 SHALL compute MUL as unsigned shift-add, one bit per cycle, out_valid exactly WIDTH+1 cycles after accept; result = low WIDTH product bits.
REQ-025 SHALL drive busy high exactly while in MUL.

Reset
REQ-026 SHALL, on rising edge with rst_n low, force state IDLE, out_valid 0, busy 0, result 0, flags 4'b0000, discarding any in-progress or held operation.
REQ-027 SHALL present in_ready 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL compile MUL support only when macro ALU_CORE_MUL_EN is defined.
REQ-029 SHALL, without ALU_CORE_MUL_EN, treat opcode 8 as undefined (result 0, latency 1), omit MUL state and multiplier datapath, and tie busy to 0.

Structure
REQ-030 SHALL place opcode constants (OP_ADD..OP_MUL), FSM state encoding and flag bit indices in shared package alu_pkg.
REQ-031 SHALL implement the shift-add multiplier as sub-module alu_mul_seq (start/done handshake), instantiated only under ALU_CORE_MUL_EN.

Verification (WIDTH=8)
REQ-032 SHALL cover ADD A=0x0A B=0x05 -> result 0x0F, flags 0000, out_valid 1 cycle after accept.
REQ-033 SHALL cover ADD 0xFF+0x01 -> 0x00, Z=1 C=1; SUB 0x05-0x0A -> 0xFB, N=1 C=1; ADD 0x7F+0x01 -> 0x80, N=1 V=1.
REQ-034 SHALL cover backpressure: out_ready low 3 cycles after SUB result -> result/flags unchanged, in_ready 0; out_ready high with in_valid high -> back-to-back accept, no bubble.
REQ-035 SHALL cover MUL (macro defined) 0x0C*0x0B -> 0x84 C=0, out_valid 9 cycles after accept, busy high 8 cycles; 0x10*0x10 -> 0x00 Z=1 C=1.
REQ-036 SHALL cover rst_n low for one edge during MUL cycle 4 -> next cycle out_valid 0, busy 0, in_ready 1, result 0.
REQ-037 SHALL cover macro undefined: opcode 8 and opcode 15 -> result 0, Z=1, latency 1, busy never high.
